// File: rtl/alsu_param.sv
// alsu_param: two-stage registered arithmetic/logic/shift unit with an
// error-indication state machine.
//
// Stage 1 registers every input (including in_valid) on every edge.
// Stage 2 computes a result from the stage-1 values and registers it when
// the registered valid is set. Invalid operations drive a blinking LED
// pattern and a saturating error counter.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-high reset
//   in_valid   in   1          qualifies all other inputs this cycle
//   A, B       in   WIDTH      operands
//   opcode     in   3          0 AND, 1 XOR, 2 ADD, 3 MULT, 4 SHIFT, 5 ROTATE
//   cin        in   1          adder carry (used when FULL_ADDER = "ON")
//   serial_in  in   1          shift fill bit
//   direction  in   1          1 = left, 0 = right
//   red_op_A/B in   1          reduction-mode flags (opcode 0/1 only)
//   bypass_A/B in   1          pass the operand straight to out
//   out        out  2*WIDTH    registered result
//   out_valid  out  1          out was updated at the last edge
//   leds       out  LED_W      error indication
//   err_count  out  ERR_CNT_W  saturating count of invalid operations
//
// Error FSM:
//   state    | meaning
//   ST_OK    | no pending error, leds held at 0
//   ST_ERROR | last operation was invalid, leds blink every BLINK_PERIOD edges
module alsu_param #(
  parameter int WIDTH          = 3,
  parameter     INPUT_PRIORITY = "A",
  parameter     FULL_ADDER     = "ON",
  parameter int LED_W          = 16,
  parameter int BLINK_PERIOD   = 4,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  input  logic [2:0]             opcode,
  input  logic                   cin,
  input  logic                   serial_in,
  input  logic                   direction,
  input  logic                   red_op_A,
  input  logic                   red_op_B,
  input  logic                   bypass_A,
  input  logic                   bypass_B,
  output logic [2*WIDTH-1:0]     out,
  output logic                   out_valid,
  output logic [LED_W-1:0]       leds,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam bit PRIO_A = (INPUT_PRIORITY == "A");
  localparam bit FA_ON  = (FULL_ADDER == "ON");
  localparam int OW     = 2 * WIDTH;
  // Counter is at least one bit wide so BLINK_PERIOD = 1 still elaborates.
  localparam int CNT_W  = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_PERIOD - 1);

  typedef enum logic {ST_OK, ST_ERROR} state_t;

  // Stage 1
  logic             r_valid;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_opcode;
  logic             r_cin, r_serial_in, r_direction;
  logic             r_red_a, r_red_b, r_byp_a, r_byp_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_opcode    <= '0;
      r_cin       <= 1'b0;
      r_serial_in <= 1'b0;
      r_direction <= 1'b0;
      r_red_a     <= 1'b0;
      r_red_b     <= 1'b0;
      r_byp_a     <= 1'b0;
      r_byp_b     <= 1'b0;
    end else begin
      r_valid     <= in_valid;
      r_a         <= A;
      r_b         <= B;
      r_opcode    <= opcode;
      r_cin       <= cin;
      r_serial_in <= serial_in;
      r_direction <= direction;
      r_red_a     <= red_op_A;
      r_red_b     <= red_op_B;
      r_byp_a     <= bypass_A;
      r_byp_b     <= bypass_B;
    end
  end

  // Stage 2 datapath
  logic [OW-1:0]  r_out;
  logic           r_out_valid;
  logic [OW-1:0]  w_result;
  logic           w_error;
  logic           w_sel_byp_a;
  logic           w_sel_red_a;
  logic [WIDTH:0] w_sum;
  logic [OW-1:0]  w_prod;

  // With both flags set, INPUT_PRIORITY decides which operand wins.
  assign w_sel_byp_a = r_byp_a && (!r_byp_b || PRIO_A);
  assign w_sel_red_a = r_red_a && (!r_red_b || PRIO_A);

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, (FA_ON ? r_cin : 1'b0)};
  assign w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  always_comb begin
    w_result = '0;
    w_error  = 1'b0;
    if (r_byp_a || r_byp_b) begin
      w_result[WIDTH-1:0] = w_sel_byp_a ? r_a : r_b;
    end else if ((r_opcode[2:1] == 2'b11) ||
                 ((r_red_a || r_red_b) && (r_opcode[2:1] != 2'b00))) begin
      w_error = 1'b1;
    end else begin
      case (r_opcode)
        3'd0: begin
          if (w_sel_red_a)  w_result[0] = &r_a;
          else if (r_red_b) w_result[0] = &r_b;
          else              w_result[WIDTH-1:0] = r_a & r_b;
        end
        3'd1: begin
          if (w_sel_red_a)  w_result[0] = ^r_a;
          else if (r_red_b) w_result[0] = ^r_b;
          else              w_result[WIDTH-1:0] = r_a ^ r_b;
        end
        3'd2: w_result[WIDTH:0] = w_sum;
        3'd3: w_result = w_prod;
        3'd4: w_result = r_direction ? {r_out[OW-2:0], r_serial_in}
                                     : {r_serial_in, r_out[OW-1:1]};
        3'd5: w_result = r_direction ? {r_out[OW-2:0], r_out[OW-1]}
                                     : {r_out[0], r_out[OW-1:1]};
        default: w_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_valid;
      if (r_valid) r_out <= w_result;
    end
  end

  // Error FSM
  state_t               r_state, w_state_nxt;
  logic [LED_W-1:0]     r_leds, w_leds_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [ERR_CNT_W-1:0] r_err_count, w_err_nxt;
  logic                 w_err_evt, w_good;

  assign w_err_evt = r_valid && w_error;
  assign w_good    = r_valid && !w_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_OK;
      r_leds      <= '0;
      r_cnt       <= '0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_leds      <= w_leds_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err_count <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_leds_nxt  = r_leds;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err_count;
    if (w_err_evt && (r_err_count != '1)) w_err_nxt = r_err_count + ERR_CNT_W'(1);
    case (r_state)
      ST_OK: begin
        w_leds_nxt = '0;
        if (w_err_evt) begin
          w_state_nxt = ST_ERROR;
          w_leds_nxt  = '1;
          w_cnt_nxt   = '0;
        end
      end
      ST_ERROR: begin
        // A further error only bumps err_count; the blink phase is kept.
        if (w_good) begin
          w_state_nxt = ST_OK;
          w_leds_nxt  = '0;
          w_cnt_nxt   = '0;
        end else if (!w_err_evt) begin
          if (r_cnt == CNT_LAST) begin
            w_leds_nxt = ~r_leds;
            w_cnt_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_OK;
        w_leds_nxt  = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign leds      = r_leds;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_alsu_param.sv
module tb_alsu_param;

  logic        clk, rst, in_valid;
  logic [3:0]  A, B;
  logic [2:0]  opcode;
  logic        cin, serial_in, direction;
  logic        red_op_A, red_op_B, bypass_A, bypass_B;
  logic [7:0]  out;
  logic        out_valid;
  logic [15:0] leds;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  alsu_param #(
    .WIDTH(4), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"),
    .LED_W(16), .BLINK_PERIOD(4), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
    .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out), .out_valid(out_valid), .leds(leds), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       ra;
    logic       rb;
    logic       ba;
    logic       bb;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic sin, input logic dir,
                        input logic ra, input logic rb, input logic ba, input logic bb);
    in_valid = 1'b1; opcode = op; A = a; B = b; cin = c; serial_in = sin;
    direction = dir; red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_out, input logic e_v,
                         input logic [15:0] e_leds, input logic [7:0] e_err);
    chk({tag, ".out"}, 32'(out), 32'(e_out));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_v));
    chk({tag, ".leds"}, 32'(leds), 32'(e_leds));
    chk({tag, ".err_count"}, 32'(err_count), 32'(e_err));
  endtask

  initial begin
    //            op    a     b     cin   ra    rb    ba    bb    out
    vecs[0]  = '{3'd0, 4'h9, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h09};
    vecs[1]  = '{3'd0, 4'h9, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03};
    vecs[2]  = '{3'd2, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1F};
    vecs[3]  = '{3'd2, 4'h3, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07};
    vecs[4]  = '{3'd3, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE1};
    vecs[5]  = '{3'd3, 4'h7, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2A};
    vecs[6]  = '{3'd0, 4'hC, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08};
    vecs[7]  = '{3'd0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01};
    vecs[8]  = '{3'd0, 4'hE, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{3'd0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[10] = '{3'd1, 4'hC, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h06};
    vecs[11] = '{3'd1, 4'h0, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[12] = '{3'd1, 4'h0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[13] = '{3'd7, 4'h5, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05};

    rst = 1'b1;
    set_op(3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    chk_all("reset", 8'h00, 1'b0, 16'h0000, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single operations, each followed by an idle cycle.
    for (int i = 0; i < 14; i++) begin
      set_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 1'b0,
             vecs[i].ra, vecs[i].rb, vecs[i].ba, vecs[i].bb);
      tick();
      idle();
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_out, 1'b1, 16'h0000, 8'h00);
    end

    // Back-to-back shift/rotate chain on the current out.
    set_op(3'd0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_op(3'd5, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("chain.bypass", 32'(out), 32'h03);
    set_op(3'd4, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("chain.rotr", 32'(out), 32'h81);
    set_op(3'd5, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("chain.shl", 32'(out), 32'h02);
    chk("chain.shl_valid", 32'(out_valid), 32'h1);
    idle();
    tick();
    chk("chain.rotr2", 32'(out), 32'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d.out", i), 32'(out), 32'h01);
      chk($sformatf("hold%0d.valid", i), 32'(out_valid), 32'h0);
    end

    // Invalid opcode, then LED blink timing.
    set_op(3'd7, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk_all("err_entry", 8'h00, 1'b1, 16'hFFFF, 8'h01);
    repeat (3) tick();
    chk("blink3.leds", 32'(leds), 32'hFFFF);
    tick();
    chk("blink4.leds", 32'(leds), 32'h0000);
    repeat (4) tick();
    chk("blink8.leds", 32'(leds), 32'hFFFF);
    set_op(3'd0, 4'hC, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk_all("err_exit", 8'h08, 1'b1, 16'h0000, 8'h01);

    // Reduction flag with a non-logic opcode is an error.
    set_op(3'd2, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk_all("red_conflict", 8'h00, 1'b1, 16'hFFFF, 8'h02);

    // Saturation: further errors in ERROR keep leds steady.
    set_op(3'd6, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (300) tick();
    idle();
    tick();
    chk_all("saturate", 8'h00, 1'b1, 16'hFFFF, 8'hFF);

    // Asynchronous reset while in ERROR.
    tick();
    #2 rst = 1'b1;
    #1;
    chk_all("rst_in_error", 8'h00, 1'b0, 16'h0000, 8'h00);
    #2 rst = 1'b0;

    // First op after reset needs two edges.
    set_op(3'd3, 4'h9, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_rst_edge1.valid", 32'(out_valid), 32'h0);
    chk("post_rst_edge1.out", 32'(out), 32'h00);
    idle();
    tick();
    chk("mult_5a", 32'(out), 32'h5A);

    // Reset mid-cycle clears out before any edge.
    #2 rst = 1'b1;
    #1;
    chk_all("rst_midstream", 8'h00, 1'b0, 16'h0000, 8'h00);
    #2 rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
